// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_unit: architectural PC, next-PC select, stall/halt, fault trap      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        halt_i,
    input  logic        branch_taken_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] cnt_q,      cnt_d;

    logic [31:0] w_target;
    logic        w_seq;
    logic        w_oob;
    logic        w_illegal;

    always_comb begin
        w_seq = 1'b0;
        if (jalr_i) begin
            w_target = (rs1_i + imm_i) & ~32'h1;
        end else if (jal_i || branch_taken_i) begin
            w_target = pc_q + imm_i;
        end else begin
            w_target = pc_q + 32'd4;
            w_seq    = 1'b1;
        end
    end

    // Any set bit above the ROM address width means the target lies outside the ROM.
    generate
        if (IMEM_AW < 32) begin : g_range
            assign w_oob = |w_target[31:IMEM_AW];
        end else begin : g_full
            assign w_oob = 1'b0;
        end
    endgenerate

    assign w_illegal = (w_target[1:0] != 2'b00) | w_oob | (w_seq & (w_target < pc_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0;
            cnt_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (!stall_i) begin
                    if (w_illegal) begin
                        state_d    = S_FAULT;
                        fault_pc_d = w_target;
                    end else begin
                        pc_d  = w_target;
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        fetch_valid_o = (state_q == S_RUN);
        halted_o      = (state_q == S_HALT);
        fault_o       = (state_q == S_FAULT);
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + 32'd4;
    assign fault_pc_o  = fault_pc_q;
    assign fetch_cnt_o = cnt_q;

endmodule
`default_nettype wire
